// File: rtl/ks_adder_pkg.sv
// Shared sizing helpers for the pipelined Kogge-Stone adder: prefix depth and end-to-end latency.
package ks_adder_pkg;

  localparam int KS_DEF_WIDTH     = 8;
  localparam int KS_DEF_REG_EVERY = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int ks_levels(input int width);
    return clog2(width);
  endfunction

  // One register for the bitwise G/P stage plus one per group of REG_EVERY prefix levels.
  function automatic int ks_latency(input int width, input int reg_every);
    return 1 + (ks_levels(width) + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level: black cells at i>=SPAN, pass-through below.
module ks_prefix_level #(
  parameter int WIDTH = 8,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_black
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-SPAN]);
      assign p_o[i] = p_i[i] & p_i[i-SPAN];
    end else begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready stream and global stall.
// Define KS_ADD_SAT_EN to saturate the sum to all-ones on carry-out.
module ks_adder_pipe
  import ks_adder_pkg::*;
#(
  parameter int WIDTH     = KS_DEF_WIDTH,
  parameter int REG_EVERY = KS_DEF_REG_EVERY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_sat
);

  localparam int LEVELS = ks_levels(WIDTH);
  localparam int STAGES = ks_latency(WIDTH, REG_EVERY) - 1;

  logic [STAGES:0] vld_pipe_q;
  logic            stall;
  logic            adv;

  assign stall     = vld_pipe_q[STAGES] & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES];

  always_ff @(posedge clk) begin
    if (reset)    vld_pipe_q <= '0;
    else if (adv) vld_pipe_q <= {vld_pipe_q[STAGES-1:0], in_valid};
  end

  // Stage 0: bitwise generate/propagate with carry-in folded into bit 0.
  logic [WIDTH-1:0] g0_d, g0_q, p0_q;
  logic             cin0_q;

  always_comb begin
    g0_d    = a & b;
    g0_d[0] = g0_d[0] | ((a[0] ^ b[0]) & cin);
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      g0_q   <= g0_d;
      p0_q   <= a ^ b;
      cin0_q <= cin;
    end
  end

  logic [LEVELS:0][WIDTH-1:0] g_w, p_w, praw_w;
  logic [LEVELS:0]            cin_w;

  assign g_w[0]    = g0_q;
  assign p_w[0]    = p0_q;
  assign praw_w[0] = p0_q;
  assign cin_w[0]  = cin0_q;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic [WIDTH-1:0] g_nx, p_nx;

    ks_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << k)) u_lvl (
      .g_i(g_w[k]), .p_i(p_w[k]), .g_o(g_nx), .p_o(p_nx)
    );

    // The last level feeds the output register directly, so it never gets its own cut.
    if (((k + 1) % REG_EVERY == 0) && (k < LEVELS - 1)) begin : g_reg
      logic [WIDTH-1:0] g_q, p_q, praw_q;
      logic             cin_q;
      always_ff @(posedge clk) begin
        if (adv) begin
          g_q    <= g_nx;
          p_q    <= p_nx;
          praw_q <= praw_w[k];
          cin_q  <= cin_w[k];
        end
      end
      assign g_w[k+1]    = g_q;
      assign p_w[k+1]    = p_q;
      assign praw_w[k+1] = praw_q;
      assign cin_w[k+1]  = cin_q;
    end else begin : g_comb
      assign g_w[k+1]    = g_nx;
      assign p_w[k+1]    = p_nx;
      assign praw_w[k+1] = praw_w[k];
      assign cin_w[k+1]  = cin_w[k];
    end
  end

  logic [WIDTH-1:0] raw_sum, sum_d, sum_q;
  logic             cout_d, cout_q, sat_d, sat_q;

  assign raw_sum = praw_w[LEVELS] ^ {g_w[LEVELS][WIDTH-2:0], cin_w[LEVELS]};
  assign cout_d  = g_w[LEVELS][WIDTH-1];

`ifdef KS_ADD_SAT_EN
  assign sum_d = cout_d ? '1 : raw_sum;
  assign sat_d = cout_d;
`else
  assign sum_d = raw_sum;
  assign sat_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (adv) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      sat_q  <= sat_d;
    end
  end

  assign sum     = sum_q;
  assign cout    = cout_q;
  assign out_sat = sat_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: directed + random streams on three configurations, queue-based a+b+cin model.
module tb_ks_adder_pipe;

`ifdef KS_ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic r8 = 1'b1, iv8 = 1'b0, c8 = 1'b0, or8 = 1'b1, ir8, ov8, co8, st8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic r6 = 1'b1, iv6 = 1'b0, c6 = 1'b0, or6 = 1'b1, ir6, ov6, co6, st6;
  logic [5:0] a6 = '0, b6 = '0, s6;
  logic r13 = 1'b1, iv13 = 1'b0, c13 = 1'b0, or13 = 1'b1, ir13, ov13, co13, st13;
  logic [12:0] a13 = '0, b13 = '0, s13;

  ks_adder_pipe #(.WIDTH(8), .REG_EVERY(1)) u_d8 (
    .clk(clk), .reset(r8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .out_sat(st8));
  ks_adder_pipe #(.WIDTH(6), .REG_EVERY(3)) u_d6 (
    .clk(clk), .reset(r6), .in_valid(iv6), .in_ready(ir6), .a(a6), .b(b6), .cin(c6),
    .out_valid(ov6), .out_ready(or6), .sum(s6), .cout(co6), .out_sat(st6));
  ks_adder_pipe #(.WIDTH(13), .REG_EVERY(2)) u_d13 (
    .clk(clk), .reset(r13), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13), .cin(c13),
    .out_valid(ov13), .out_ready(or13), .sum(s13), .cout(co13), .out_sat(st13));

  // Model: the full-precision a+b+cin decides every output.
  function automatic int exp_sum(input int full, input int w);
`ifdef KS_ADD_SAT_EN
    if ((full >> w) != 0) return (1 << w) - 1;
`endif
    return full & ((1 << w) - 1);
  endfunction

  function automatic int exp_sat(input int full, input int w);
    return SAT ? ((full >> w) & 1) : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int full, input int w,
                         input logic [31:0] s, input logic co, input logic st);
    chk({tag, " sum"}, s, exp_sum(full, w));
    chk({tag, " cout"}, {31'd0, co}, (full >> w) & 1);
    chk({tag, " sat"}, {31'd0, st}, exp_sat(full, w));
  endtask

  task automatic extra(input string tag, input int s);
    tests++;
    fails++;
    $display("FAIL %s extra result: got sum 0x%0h, expected no output", tag, s);
  endtask

  int q8[$], q6[$], q13[$];

  always @(negedge clk) begin
    if (r8) q8.delete();
    else begin
      if (ov8 && or8) begin
        if (q8.size() == 0) extra("d8", int'(s8));
        else chk_res("d8", q8.pop_front(), 8, s8, co8, st8);
      end
      if (iv8 && ir8) q8.push_back(int'(a8) + int'(b8) + int'(c8));
    end
  end

  always @(negedge clk) begin
    if (r6) q6.delete();
    else begin
      if (ov6 && or6) begin
        if (q6.size() == 0) extra("d6", int'(s6));
        else chk_res("d6", q6.pop_front(), 6, s6, co6, st6);
      end
      if (iv6 && ir6) q6.push_back(int'(a6) + int'(b6) + int'(c6));
    end
  end

  always @(negedge clk) begin
    if (r13) q13.delete();
    else begin
      if (ov13 && or13) begin
        if (q13.size() == 0) extra("d13", int'(s13));
        else chk_res("d13", q13.pop_front(), 13, s13, co13, st13);
      end
      if (iv13 && ir13) q13.push_back(int'(a13) + int'(b13) + int'(c13));
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int t;
    a8 = a; b8 = b; c8 = c; iv8 = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!ir8 && t < 100);
    if (!ir8) begin
      tests++; fails++;
      $display("FAIL d8 send timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic run8();
    int n;
    logic [7:0] rec_s;
    logic rec_c;
    // reset held two edges with in_valid high
    iv8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst out_valid", ov8, 0);
      chk("rst sum", s8, 0);
      chk("rst cout", co8, 0);
      chk("rst out_sat", st8, 0);
      chk("rst in_ready", ir8, 1);
    end
    r8 = 1'b0; iv8 = 1'b0;

    // latency and carry-out boundary
    send8(8'hFF, 8'h01, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!ov8 && n < 20);
    chk("lat8", n, 4);
    chk("ff+01 sum", s8, SAT ? 32'hFF : 32'h00);
    chk("ff+01 cout", co8, 1);
    chk("ff+01 sat", st8, SAT ? 32'd1 : 32'd0);
    @(posedge clk); #1;

    // back-to-back results on consecutive cycles
    send8(8'h12, 8'h34, 1'b0);
    send8(8'h80, 8'h80, 1'b1);
    send8(8'h7F, 8'h00, 1'b1);
    @(negedge clk);
    chk("b2b cycle3 out_valid", ov8, 0);
    @(negedge clk);
    chk("b2b r0 valid", ov8, 1); chk("b2b r0 sum", s8, 32'h46); chk("b2b r0 cout", co8, 0);
    @(negedge clk);
    chk("b2b r1 valid", ov8, 1); chk("b2b r1 sum", s8, SAT ? 32'hFF : 32'h01); chk("b2b r1 cout", co8, 1);
    @(negedge clk);
    chk("b2b r2 valid", ov8, 1); chk("b2b r2 sum", s8, 32'h80); chk("b2b r2 cout", co8, 0);
    @(posedge clk); #1;

    // stall with results waiting
    or8 = 1'b0;
    send8(8'h01, 8'h02, 1'b0);
    send8(8'hF0, 8'h20, 1'b0);
    send8(8'h33, 8'h44, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("stall head valid", ov8, 1);
    chk("stall head sum", s8, 32'h03);
    rec_s = s8; rec_c = co8;
    repeat (3) begin
      @(negedge clk);
      chk("stall in_ready", ir8, 0);
      chk("stall out_valid", ov8, 1);
      chk("stall sum stable", s8, rec_s);
      chk("stall cout stable", co8, rec_c);
    end
    @(posedge clk); #1;
    or8 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("stall drain", q8.size(), 0);

    // reset with ops in flight
    send8(8'h11, 8'h22, 1'b0);
    send8(8'h33, 8'h44, 1'b0);
    send8(8'h55, 8'h66, 1'b1);
    r8 = 1'b1;
    @(posedge clk); #1;
    r8 = 1'b0;
    chk("midrst out_valid", ov8, 0);
    chk("midrst in_ready", ir8, 1);
    n = 0;
    repeat (10) begin @(negedge clk); if (ov8) n++; end
    chk("midrst stale results", n, 0);

    // random traffic with random backpressure
    repeat (400) begin
      @(posedge clk); #1;
      iv8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      or8 = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("d8 random drain", q8.size(), 0);
  endtask

  task automatic run6();
    int n;
    int idx;
    logic [12:0] v;
    repeat (2) @(posedge clk);
    #1;
    r6 = 1'b0;
    a6 = 6'h3F; b6 = 6'h01; c6 = 1'b0; iv6 = 1'b1;
    @(posedge clk); #1;
    iv6 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ov6 && n < 20);
    chk("lat6", n, 2);
    chk("3f+01 sum", s6, SAT ? 32'h3F : 32'h00);
    chk("3f+01 cout", co6, 1);
    @(posedge clk); #1;
    idx = 0;
    while (idx < 8192) begin
      v = idx[12:0];
      {c6, a6, b6} = v;
      iv6 = 1'b1;
      or6 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (ir6) idx++;
      @(posedge clk); #1;
    end
    iv6 = 1'b0; or6 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("d6 exhaustive drain", q6.size(), 0);
  endtask

  task automatic run13();
    int n;
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    r13 = 1'b0;
    a13 = 13'h1FFF; b13 = 13'h0001; c13 = 1'b1; iv13 = 1'b1;
    @(posedge clk); #1;
    iv13 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ov13 && n < 20);
    chk("lat13", n, 3);
    chk("1fff+1+1 sum", s13, SAT ? 32'h1FFF : 32'h0001);
    chk("1fff+1+1 cout", co13, 1);
    @(posedge clk); #1;
    cnt = 0;
    while (cnt < 10000) begin
      a13 = 13'($urandom); b13 = 13'($urandom); c13 = 1'($urandom);
      iv13 = 1'b1;
      or13 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (ir13) cnt++;
      @(posedge clk); #1;
    end
    iv13 = 1'b0; or13 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("d13 random drain", q13.size(), 0);
  endtask

  initial begin
    fork
      run8();
      run6();
      run13();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
